// File: rtl/time_display_mux.sv
// time_display_mux
// ----------------
// Converts a packed binary time word (hours/minutes/seconds) into six BCD
// digits using a repeated-subtract-ten converter, then multiplexes the
// digits onto a common 7-segment bus with a one-hot digit enable.
//
// Handshake: a word is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready is low while a conversion runs, and
// in_valid during that time is ignored (no queueing). The display register
// only changes at the end of a conversion, so scanning is never disturbed.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   time_in   [16:12] hours, [11:6] minutes, [5:0] seconds
//   mode12    1 = time_in[16] is the PM flag, [15:12] the hour (0 shown as 12)
//   in_valid  time_in/mode12 are valid this cycle
//   in_ready  high when no conversion is in progress
//   seg       segments a..g on bits 0..6, active-high, registered
//   an        one-hot digit enable (an[0] seconds units, an[5] hour tens)
//   dp        decimal point, high while an[2] or an[4] is enabled
//   pm_led    committed PM flag
//
// Build option: define TIME_DISPLAY_HOUR_BLANK_EN to blank a zero hour-tens
// digit (an[5] stays asserted, segments all off).

module time_display_mux #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] time_in,
    input  logic        mode12,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        dp,
    output logic        pm_led
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_commit;
    logic   w_all_small;

    // Conversion working registers
    logic [4:0] r_hr;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic [1:0] r_hr_t;
    logic [2:0] r_min_t;
    logic [2:0] r_sec_t;
    logic       r_pm_work;

    // Display register: index 0 = seconds units ... 5 = hour tens
    logic [5:0][3:0] r_disp;
    logic            r_disp_pm;

    // Scanner
    logic [CW-1:0] r_scan_cnt;
    logic [2:0]    r_digit_idx;

    // Output stage next values
    logic [3:0] w_digit;
    logic [6:0] w_seg_nxt;
    logic [5:0] w_an_nxt;
    logic       w_dp_nxt;

    logic [4:0] w_hr_ld;
    logic       w_pm_ld;

    assign in_ready    = (r_state == ST_IDLE);
    assign w_all_small = (r_hr < 5'd10) && (r_min < 6'd10) && (r_sec < 6'd10);

    // 12h mode: a zero hour is displayed as 12
    always_comb begin
        w_hr_ld = time_in[16:12];
        w_pm_ld = 1'b0;
        if (mode12) begin
            w_pm_ld = time_in[16];
            if (time_in[15:12] == 4'd0) begin
                w_hr_ld = 5'd12;
            end else begin
                w_hr_ld = {1'b0, time_in[15:12]};
            end
        end
    end

    // ---------------- Control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                if (w_all_small) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Converter datapath ----------------
    // All three fields reduce in parallel, so latency is set by the largest
    // tens digit, not by the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hr      <= '0;
            r_min     <= '0;
            r_sec     <= '0;
            r_hr_t    <= '0;
            r_min_t   <= '0;
            r_sec_t   <= '0;
            r_pm_work <= 1'b0;
            r_disp    <= '0;
            r_disp_pm <= 1'b0;
        end else if (w_accept) begin
            r_hr      <= w_hr_ld;
            r_min     <= time_in[11:6];
            r_sec     <= time_in[5:0];
            r_hr_t    <= '0;
            r_min_t   <= '0;
            r_sec_t   <= '0;
            r_pm_work <= w_pm_ld;
        end else if (w_commit) begin
            r_disp[0] <= r_sec[3:0];
            r_disp[1] <= {1'b0, r_sec_t};
            r_disp[2] <= r_min[3:0];
            r_disp[3] <= {1'b0, r_min_t};
            r_disp[4] <= r_hr[3:0];
            r_disp[5] <= {2'b00, r_hr_t};
            r_disp_pm <= r_pm_work;
        end else if (r_state == ST_CONV) begin
            if (r_hr >= 5'd10) begin
                r_hr   <= r_hr - 5'd10;
                r_hr_t <= r_hr_t + 2'd1;
            end
            if (r_min >= 6'd10) begin
                r_min   <= r_min - 6'd10;
                r_min_t <= r_min_t + 3'd1;
            end
            if (r_sec >= 6'd10) begin
                r_sec   <= r_sec - 6'd10;
                r_sec_t <= r_sec_t + 3'd1;
            end
        end
    end

    // ---------------- Scanner ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 3'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= (r_digit_idx == 3'd5) ? 3'd0 : r_digit_idx + 3'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + CW'(1);
        end
    end

    always_comb begin
        w_digit = 4'd0;
        case (r_digit_idx)
            3'd0:    w_digit = r_disp[0];
            3'd1:    w_digit = r_disp[1];
            3'd2:    w_digit = r_disp[2];
            3'd3:    w_digit = r_disp[3];
            3'd4:    w_digit = r_disp[4];
            3'd5:    w_digit = r_disp[5];
            default: w_digit = 4'd0;
        endcase
    end

    always_comb begin
        w_seg_nxt = 7'b0000000;
        case (w_digit)
            4'd0:    w_seg_nxt = 7'b0111111;
            4'd1:    w_seg_nxt = 7'b0000110;
            4'd2:    w_seg_nxt = 7'b1011011;
            4'd3:    w_seg_nxt = 7'b1001111;
            4'd4:    w_seg_nxt = 7'b1100110;
            4'd5:    w_seg_nxt = 7'b1101101;
            4'd6:    w_seg_nxt = 7'b1111101;
            4'd7:    w_seg_nxt = 7'b0000111;
            4'd8:    w_seg_nxt = 7'b1111111;
            4'd9:    w_seg_nxt = 7'b1101111;
            default: w_seg_nxt = 7'b0000000;
        endcase
`ifdef TIME_DISPLAY_HOUR_BLANK_EN
        if ((r_digit_idx == 3'd5) && (w_digit == 4'd0)) begin
            w_seg_nxt = 7'b0000000;
        end
`endif
    end

    always_comb begin
        w_an_nxt = 6'd1 << r_digit_idx;
        w_dp_nxt = (r_digit_idx == 3'd2) || (r_digit_idx == 3'd4);
    end

    // Registered outputs, one cycle behind the digit index / display register
    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= 7'b0000000;
            an     <= 6'b000000;
            dp     <= 1'b0;
            pm_led <= 1'b0;
        end else begin
            seg    <= w_seg_nxt;
            an     <= w_an_nxt;
            dp     <= w_dp_nxt;
            pm_led <= r_disp_pm;
        end
    end

endmodule

// File: tb/tb_time_display_mux.sv
// Directed testbench for time_display_mux (SCAN_DIV = 4).
// Honours TIME_DISPLAY_HOUR_BLANK_EN the same way as the design.

module tb_time_display_mux;

    logic        clk;
    logic        rst;
    logic [16:0] time_in;
    logic        mode12;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        dp;
    logic        pm_led;

    int n_checks = 0;
    int n_pass   = 0;

    time_display_mux #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .time_in  (time_in),
        .mode12   (mode12),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .seg      (seg),
        .an       (an),
        .dp       (dp),
        .pm_led   (pm_led)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input int d);
`ifdef TIME_DISPLAY_HOUR_BLANK_EN
        if (idx == 5 && d == 0) return 7'b0000000;
`endif
        return seg_of(d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic logic [16:0] pack_t(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    // Caller is at a negedge; returns at the negedge just after the accept edge.
    task automatic send(input logic [16:0] t, input logic m12);
        time_in  = t;
        mode12   = m12;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Digits given most significant first: hour tens .. seconds units.
    task automatic check_display(input string tag, input int h1, input int h0,
                                 input int m1, input int m0, input int s1,
                                 input int s0, input logic pm);
        int d[6];
        d[0] = s0; d[1] = s1; d[2] = m0; d[3] = m1; d[4] = h0; d[5] = h1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 30 && an !== (6'd1 << i); k++) @(negedge clk);
            chk({tag, "_an"}, 32'(an), 32'(6'd1 << i));
            chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(i, d[i])));
            chk({tag, "_dp"}, 32'(dp), 32'((i == 2 || i == 4) ? 1 : 0));
            chk({tag, "_pm"}, 32'(pm_led), 32'(pm));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        time_in  = '0;
        mode12   = 1'b0;
        in_valid = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_dp", 32'(dp), 32'd0);
        chk("rst_pm", 32'(pm_led), 32'd0);

        // Scan walk after release: each digit held 4 cycles, then wraps
        rst = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            int idx;
            @(negedge clk);
            idx = (c / 4) % 6;
            chk("scan_an", 32'(an), 32'(6'd1 << idx));
            chk("scan_seg", 32'(seg), 32'(exp_seg(idx, 0)));
            chk("scan_dp", 32'(dp), 32'((idx == 2 || idx == 4) ? 1 : 0));
        end

        // 23:59:45 in 24h mode: busy for 6 cycles
        send(pack_t(23, 59, 45), 1'b0);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            chk("busy_235945", 32'(in_ready), 32'((c < 6) ? 0 : 1));
        end
        check_display("disp_235945", 2, 3, 5, 9, 4, 5, 1'b0);

        // 12h mode, PM flag set, hour 0 -> 12 PM
        send(17'b10000_000000_000000, 1'b1);
        check_display("disp_12pm", 1, 2, 0, 0, 0, 0, 1'b1);

        // Second request while busy is dropped
        send(pack_t(23, 59, 45), 1'b0);
        time_in  = pack_t(1, 2, 3);
        mode12   = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("drop_busy", 32'(in_ready), 32'd0);
        repeat (10) @(negedge clk);
        check_display("disp_drop", 2, 3, 5, 9, 4, 5, 1'b0);

        // Out-of-range fields pass through: 00:60:63, busy 7 cycles
        send(pack_t(0, 60, 63), 1'b0);
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) @(negedge clk);
            chk("busy_006063", 32'(in_ready), 32'((c < 7) ? 0 : 1));
        end
        check_display("disp_006063", 0, 0, 6, 0, 6, 3, 1'b0);

        // Reset mid-conversion aborts it; display returns to zeros
        send(pack_t(23, 59, 45), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(in_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("abort_ready_hold", 32'(in_ready), 32'd1);
        check_display("disp_abort", 0, 0, 0, 0, 0, 0, 1'b0);

        // 05:00:00 -> hour tens zero (blanked when the option is built in)
        send(pack_t(5, 0, 0), 1'b0);
        check_display("disp_050000", 0, 5, 0, 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
